// File: rtl/traffic_light_fsm.sv
// RED -> GREEN -> YELLOW phase sequencer with pedestrian early exit of GREEN.
// Optional yellow-flash fault mode is built when TL_FAULT_FLASH_EN is defined.
module traffic_light_fsm #(
    parameter int RED_CYCLES        = 8,
    parameter int GREEN_CYCLES      = 12,
    parameter int YELLOW_CYCLES     = 4,
    parameter int MIN_GREEN_CYCLES  = 5,
    parameter int FLASH_HALF_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       ped_req,
`ifdef TL_FAULT_FLASH_EN
    input  logic       fault,
`endif
    output logic [1:0] traffic_state,
    output logic       red_on,
    output logic       yel_on,
    output logic       grn_on,
    output logic       ped_ack,
    output logic       state_change
);

    localparam int MAX_RG  = (RED_CYCLES > GREEN_CYCLES) ? RED_CYCLES : GREEN_CYCLES;
    localparam int MAX_YF  = (YELLOW_CYCLES > FLASH_HALF_CYCLES) ? YELLOW_CYCLES : FLASH_HALF_CYCLES;
    localparam int MAX_DUR = (MAX_RG > MAX_YF) ? MAX_RG : MAX_YF;
    localparam int CNT_W   = $clog2(MAX_DUR) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN_CYCLES - 1);
`ifdef TL_FAULT_FLASH_EN
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_HALF_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_RED    = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10
`ifdef TL_FAULT_FLASH_EN
        , ST_FLASH = 2'b11
`endif
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ped_pend_r;
    logic             ped_pend_nxt_s;
    logic             served_r;
    logic             served_nxt_s;
    logic             ack_nxt_s;
    logic             chg_nxt_s;
`ifdef TL_FAULT_FLASH_EN
    logic             flash_yel_r;
    logic             flash_yel_nxt_s;
`endif

    function automatic logic [1:0] state_code(input state_t st);
        case (st)
            ST_RED:    state_code = 2'b00;
            ST_GREEN:  state_code = 2'b01;
            ST_YELLOW: state_code = 2'b10;
`ifdef TL_FAULT_FLASH_EN
            ST_FLASH:  state_code = 2'b10;
`endif
            default:   state_code = 2'b00;
        endcase
    endfunction

    // Next-state, counter, pedestrian bookkeeping and pulse generation.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        ped_pend_nxt_s = ped_pend_r | ped_req;
        served_nxt_s   = served_r;
        ack_nxt_s      = 1'b0;
        chg_nxt_s      = 1'b0;
`ifdef TL_FAULT_FLASH_EN
        flash_yel_nxt_s = flash_yel_r;
        if (fault) begin
            ped_pend_nxt_s = 1'b0;
            served_nxt_s   = 1'b0;
            if (state_r == ST_FLASH) begin
                if (cnt_r == FLASH_LAST) begin
                    cnt_nxt_s       = '0;
                    flash_yel_nxt_s = ~flash_yel_r;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end else begin
                state_nxt_s     = ST_FLASH;
                cnt_nxt_s       = '0;
                flash_yel_nxt_s = 1'b1;
                chg_nxt_s       = 1'b1;
            end
        end else if (state_r == ST_FLASH) begin
            state_nxt_s     = ST_RED;
            cnt_nxt_s       = '0;
            ped_pend_nxt_s  = 1'b0;
            served_nxt_s    = 1'b0;
            flash_yel_nxt_s = 1'b0;
            chg_nxt_s       = 1'b1;
        end else
`endif
        if (enable) begin
            case (state_r)
                ST_RED: begin
                    if (cnt_r == RED_LAST) begin
                        state_nxt_s = ST_GREEN;
                        cnt_nxt_s   = '0;
                        chg_nxt_s   = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_GREEN: begin
                    if ((cnt_r == GREEN_LAST) || (ped_pend_r && (cnt_r >= MIN_LAST))) begin
                        state_nxt_s  = ST_YELLOW;
                        cnt_nxt_s    = '0;
                        chg_nxt_s    = 1'b1;
                        served_nxt_s = ped_pend_r;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_YELLOW: begin
                    if (cnt_r == YELLOW_LAST) begin
                        state_nxt_s  = ST_RED;
                        cnt_nxt_s    = '0;
                        chg_nxt_s    = 1'b1;
                        served_nxt_s = 1'b0;
                        // Only the request served by this YELLOW is retired; a fresh one wins.
                        if (served_r) begin
                            ped_pend_nxt_s = ped_req;
                            ack_nxt_s      = 1'b1;
                        end else begin
                            ped_pend_nxt_s = ped_pend_r | ped_req;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_RED;
                    cnt_nxt_s   = '0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State registers; lamps and phase code are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_RED;
            cnt_r         <= '0;
            ped_pend_r    <= 1'b0;
            served_r      <= 1'b0;
            traffic_state <= 2'b00;
            red_on        <= 1'b1;
            yel_on        <= 1'b0;
            grn_on        <= 1'b0;
            ped_ack       <= 1'b0;
            state_change  <= 1'b0;
`ifdef TL_FAULT_FLASH_EN
            flash_yel_r   <= 1'b0;
`endif
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            ped_pend_r    <= ped_pend_nxt_s;
            served_r      <= served_nxt_s;
            traffic_state <= state_code(state_nxt_s);
            red_on        <= (state_nxt_s == ST_RED);
            grn_on        <= (state_nxt_s == ST_GREEN);
`ifdef TL_FAULT_FLASH_EN
            yel_on        <= (state_nxt_s == ST_YELLOW) ||
                             ((state_nxt_s == ST_FLASH) && flash_yel_nxt_s);
            flash_yel_r   <= flash_yel_nxt_s;
`else
            yel_on        <= (state_nxt_s == ST_YELLOW);
`endif
            ped_ack       <= ack_nxt_s;
            state_change  <= chg_nxt_s;
        end
    end

endmodule
